// File: rtl/ahb_lite_req_arbiter_if.sv
// Request/response and AHB-Lite signal bundle for the two-requester arbiter.
// master = arbiter side, slave = requesters plus AHB slave environment.
interface ahb_lite_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [5:0]          req_size;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [ADDR_W-1:0]   HADDR;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [1:0]          HTRANS;
  logic [2:0]          HBURST;
  logic [3:0]          HPROT;
  logic [DATA_W-1:0]   HWDATA;
  logic [DATA_W-1:0]   HRDATA;
  logic                HREADY;
  logic                HRESP;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size,
    input  HRDATA, HREADY, HRESP,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size,
    output HRDATA, HREADY, HRESP,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_lite_req_arbiter.sv
// Two-requester AHB-Lite master front end; zero-wait read: accept edge 0, NONSEQ cycle 1, rsp cycle 3.
// Wait states stall both slots and block grants; AHBL_ARB_FIXED_PRIO_EN selects fixed priority (req 0).
module ahb_lite_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_req_arbiter_if.master bus
);

  // address slot
  logic              a_vld;
  logic              a_own;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write;
  logic [2:0]        a_size;
  logic [DATA_W-1:0] a_wdata;
  // data slot
  logic              d_vld;
  logic              d_own;
  logic              d_write;
  logic [DATA_W-1:0] d_wdata;

  logic              cancel;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
`ifndef AHBL_ARB_FIXED_PRIO_EN
  logic              rr;
`endif

  logic              adv;
  logic              complete;
  logic              slot_free;
  logic [1:0]        gnt;
  logic [1:0]        ready;
  logic              accept;
  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_size;
  logic              sel_write;

  always_comb begin
    adv       = a_vld & ~cancel & bus.HREADY;
    complete  = d_vld & bus.HREADY;
    // a cancelled slot is held until the retry, so it blocks new grants
    slot_free = ~a_vld | adv;
    gnt       = 2'b00;
`ifdef AHBL_ARB_FIXED_PRIO_EN
    if (bus.req_valid[0])      gnt = 2'b01;
    else if (bus.req_valid[1]) gnt = 2'b10;
`else
    if (bus.req_valid == 2'b11) gnt = rr ? 2'b10 : 2'b01;
    else                        gnt = bus.req_valid;
`endif
    ready     = (HRESETn && slot_free) ? gnt : 2'b00;
    accept    = |(bus.req_valid & ready);
    win       = gnt[1];
    sel_addr  = win ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
    sel_wdata = win ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
    sel_size  = win ? bus.req_size[5:3] : bus.req_size[2:0];
    sel_write = win ? bus.req_write[1]  : bus.req_write[0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_vld       <= 1'b0;
      a_own       <= 1'b0;
      a_addr      <= '0;
      a_write     <= 1'b0;
      a_size      <= 3'b000;
      a_wdata     <= '0;
      d_vld       <= 1'b0;
      d_own       <= 1'b0;
      d_write     <= 1'b0;
      d_wdata     <= '0;
      cancel      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifndef AHBL_ARB_FIXED_PRIO_EN
      rr          <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_vld   <= 1'b1;
        a_own   <= win;
        a_addr  <= sel_addr;
        a_write <= sel_write;
        a_size  <= sel_size;
        a_wdata <= sel_wdata;
`ifndef AHBL_ARB_FIXED_PRIO_EN
        rr      <= ~win;
`endif
      end else if (adv) begin
        a_vld <= 1'b0;
      end

      if (adv) begin
        d_vld   <= 1'b1;
        d_own   <= a_own;
        d_write <= a_write;
        // reads leave the bus write data at its last value
        if (a_write) d_wdata <= a_wdata;
      end else if (complete) begin
        d_vld <= 1'b0;
      end

      if (bus.HREADY)                cancel <= 1'b0;
      else if (d_vld && bus.HRESP)   cancel <= 1'b1;

      rsp_valid_q <= complete ? (d_own ? 2'b10 : 2'b01) : 2'b00;
      if (complete) begin
        rsp_rdata_q <= d_write ? '0 : bus.HRDATA;
        rsp_err_q   <= bus.HRESP;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.HADDR     = a_addr;
  assign bus.HWRITE    = a_write;
  assign bus.HSIZE     = a_size;
  assign bus.HTRANS    = {a_vld & ~cancel, 1'b0};
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HWDATA    = d_wdata;

endmodule

// File: tb/tb_ahb_lite_req_arbiter.sv
// Directed bench for ahb_lite_req_arbiter: single read, arbitration, wait states, error retry, reset.
module tb_ahb_lite_req_arbiter;
  logic HCLK;
  logic HRESETn;
  int   errors;
  int   checks;

  ahb_lite_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_lite_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_size  = 6'b010_010;
    bus.HRDATA    = 32'h0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  function automatic logic seq_owner(int n);
`ifdef AHBL_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return (n % 2) == 1;
`endif
  endfunction

  task automatic test_reset;
    idle_inputs();
    bus.req_valid = 2'b11;
    HRESETn = 1'b0;
    tick();
    tick();
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b exp 00", bus.HTRANS); end
    checks++; if (bus.HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h exp 0", bus.HADDR); end
    checks++; if (bus.HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h exp 0", bus.HWDATA); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 00", bus.rsp_valid); end
    checks++; if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011) begin errors++; $display("FAIL rst_tied: got %b/%b exp 000/0011", bus.HBURST, bus.HPROT); end
    bus.req_valid = 2'b00;
    HRESETn = 1'b1;
  endtask

  task automatic test_single_read;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr[31:0] = 32'h100;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready: got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL rd_htrans_c1: got %b exp 10", bus.HTRANS); end
    checks++; if (bus.HADDR !== 32'h100) begin errors++; $display("FAIL rd_haddr: got %h exp 100", bus.HADDR); end
    checks++; if (bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'b010) begin errors++; $display("FAIL rd_ctrl: got %b/%b exp 0/010", bus.HWRITE, bus.HSIZE); end
    tick();
    bus.HRDATA = 32'hDEADBEEF;
    #1;
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rd_htrans_c2: got %b exp 00", bus.HTRANS); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_early: got %b exp 00", bus.rsp_valid); end
    tick();
    bus.HRDATA = 32'h0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid: got %b exp 01", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp_rdata: got %h exp deadbeef", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err: got %b exp 0", bus.rsp_err); end
    tick();
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_pulse: got %b exp 00", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [1:0]  exp_rsp;
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_write = 2'b11;
    bus.req_addr  = {32'h20, 32'h10};
    bus.req_wdata = {32'h22, 32'h11};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready_c0: got %b exp 01", bus.req_ready); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1;
      exp_addr = seq_owner(k - 1) ? 32'h20 : 32'h10;
      exp_rdy  = seq_owner(k) ? 2'b10 : 2'b01;
      checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== exp_addr) begin errors++; $display("FAIL b2b_addr c%0d: got %b/%h exp 10/%h", k, bus.HTRANS, bus.HADDR, exp_addr); end
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c%0d: got %b exp %b", k, bus.req_ready, exp_rdy); end
      if (k >= 2) begin
        exp_wd = seq_owner(k - 2) ? 32'h22 : 32'h11;
        checks++; if (bus.HWDATA !== exp_wd) begin errors++; $display("FAIL b2b_hwdata c%0d: got %h exp %h", k, bus.HWDATA, exp_wd); end
      end
      if (k >= 3) begin
        exp_rsp = seq_owner(k - 3) ? 2'b10 : 2'b01;
        checks++; if (bus.rsp_valid !== exp_rsp || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rsp c%0d: got %b/%h exp %b/0", k, bus.rsp_valid, bus.rsp_rdata, exp_rsp); end
      end
    end
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_wait_states;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr  = {32'h48, 32'h40};
    bus.req_wdata = {32'h0, 32'hA5A50040};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL ws_ready_c0: got %b exp 01", bus.req_ready); end
    tick();
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h48, 32'h44};
    #1;
    checks++; if (bus.HADDR !== 32'h40 || bus.HWRITE !== 1'b1) begin errors++; $display("FAIL ws_write_addr: got %h/%b exp 40/1", bus.HADDR, bus.HWRITE); end
    tick();
    bus.req_valid = 2'b10;
    bus.HREADY = 1'b0;
    #1;
    checks++; if (bus.HWDATA !== 32'hA5A50040) begin errors++; $display("FAIL ws_hwdata: got %h exp a5a50040", bus.HWDATA); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL ws_ready_stall1: got %b exp 00", bus.req_ready); end
    tick();
    #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h44) begin errors++; $display("FAIL ws_hold: got %b/%h exp 10/44", bus.HTRANS, bus.HADDR); end
    checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL ws_stall2: got %b/%b exp 00/00", bus.req_ready, bus.rsp_valid); end
    tick();
    bus.HREADY = 1'b1;
    #1;
    checks++; if (bus.HADDR !== 32'h44 || bus.HTRANS !== 2'b10) begin errors++; $display("FAIL ws_hold2: got %b/%h exp 10/44", bus.HTRANS, bus.HADDR); end
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL ws_ready_resume: got %b exp 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    bus.HRDATA = 32'h44440044;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL ws_wr_rsp: got %b/%b exp 01/0", bus.rsp_valid, bus.rsp_err); end
    checks++; if (bus.HADDR !== 32'h48) begin errors++; $display("FAIL ws_next_addr: got %h exp 48", bus.HADDR); end
    tick();
    bus.HRDATA = 32'h48480048;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'h44440044) begin errors++; $display("FAIL ws_rd_rsp: got %b/%h exp 01/44440044", bus.rsp_valid, bus.rsp_rdata); end
    tick();
    bus.HRDATA = 32'h0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h48480048) begin errors++; $display("FAIL ws_rd1_rsp: got %b/%h exp 10/48480048", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_error;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h88, 32'h80};
    tick();
    bus.req_addr  = {32'h88, 32'h84};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL err_ready_c1: got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b10;
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h84) begin errors++; $display("FAIL err_c2_addr: got %b/%h exp 10/84", bus.HTRANS, bus.HADDR); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL err_c2_ready: got %b exp 00", bus.req_ready); end
    tick();
    bus.HREADY = 1'b1;
    #1;
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL err_cancel_idle: got %b exp 00", bus.HTRANS); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL err_c3_ready: got %b exp 00", bus.req_ready); end
    tick();
    bus.HRESP = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1) begin errors++; $display("FAIL err_rsp: got %b/%b exp 01/1", bus.rsp_valid, bus.rsp_err); end
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h84) begin errors++; $display("FAIL err_reissue: got %b/%h exp 10/84", bus.HTRANS, bus.HADDR); end
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL err_c4_ready: got %b exp 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    bus.HRDATA = 32'h84848484;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.HADDR !== 32'h88) begin errors++; $display("FAIL err_c5: got %b/%h exp 00/88", bus.rsp_valid, bus.HADDR); end
    tick();
    bus.HRDATA = 32'h88888888;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h84848484) begin errors++; $display("FAIL err_retry_rsp: got %b/%b/%h exp 01/0/84848484", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    tick();
    bus.HRDATA = 32'h0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h88888888) begin errors++; $display("FAIL err_r1_rsp: got %b/%h exp 10/88888888", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr  = {32'h400, 32'h200};
    bus.req_wdata = {32'h0, 32'h12345678};
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.HREADY = 1'b0;
    #1;
    checks++; if (bus.HWDATA !== 32'h12345678) begin errors++; $display("FAIL rm_dphase: got %h exp 12345678", bus.HWDATA); end
    HRESETn = 1'b0;
    #1;
    checks++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_immediate: got %b/%b exp 00/00", bus.HTRANS, bus.rsp_valid); end
    checks++; if (bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0) begin errors++; $display("FAIL rm_bus_zero: got %h/%h exp 0/0", bus.HADDR, bus.HWDATA); end
    tick();
    bus.HREADY = 1'b1;
    tick();
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_rsp c%0d: got %b exp 00", k, bus.rsp_valid); end
    end
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h400, 32'h300};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h300) begin errors++; $display("FAIL rm_first_addr: got %b/%h exp 10/300", bus.HTRANS, bus.HADDR); end
    tick();
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    HRESETn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
